// File: rtl/data_ram_pkg.sv
// Shared definitions for the MCU51 internal data RAM: FSM encodings, default
// address-map limits and the bit-merge used by read-modify-write bit stores.
package data_ram_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE  = 2'd0;
  localparam state_t ST_RDATA = 2'd1;
  localparam state_t ST_MERGE = 2'd2;

  localparam logic [7:0] RN_TOP_DEF   = 8'h1F;
  localparam logic [7:0] BIT_BASE_DEF = 8'h20;
  localparam logic [7:0] BIT_TOP_DEF  = 8'h2F;

  // Selected bits take bit_val, the rest keep the stored value.
  function automatic logic [7:0] bit_merge(input logic [7:0] old_byte,
                                           input logic [7:0] mask,
                                           input logic       bit_val);
    return (old_byte & ~mask) | ({8{bit_val}} & mask);
  endfunction

endpackage

// File: rtl/data_ram_array.sv
// Single-port DEPTH x 8 storage: one read or one write per cycle,
// synchronous write and registered read so it maps onto block RAM.
module data_ram_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);

  logic [7:0] mem [DEPTH];
  logic [7:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/data_ram_rmw.sv
// MCU51 internal data RAM with byte and bit access; bit writes are an internal
// read-modify-write. Optional register-bank addressing under DATARAM_BANKSEL_EN.
module data_ram_rmw
  import data_ram_pkg::*;
#(
  parameter int         DEPTH    = 256,
  parameter logic [7:0] RN_TOP   = RN_TOP_DEF,
  parameter logic [7:0] BIT_BASE = BIT_BASE_DEF,
  parameter logic [7:0] BIT_TOP  = BIT_TOP_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       req,
  input  logic       we,
  input  logic       Bb,
  input  logic [7:0] addr,
  input  logic [7:0] position,
  input  logic [7:0] din,
  input  logic       bin,
`ifdef DATARAM_BANKSEL_EN
  input  logic [1:0] bank_sel,
  input  logic       rn_mode,
`endif
  output logic       ready,
  output logic       rvalid,
  output logic [7:0] dout,
  output logic       bout,
  output logic       err
);

  localparam int AW = $clog2(DEPTH);
  // A malformed map (bit area not above the banks) limits bit access to the banks.
  localparam logic [7:0] BIT_LIMIT =
      (BIT_TOP >= BIT_BASE && BIT_BASE > RN_TOP) ? BIT_TOP : RN_TOP;

  logic [7:0] eff_addr;
`ifdef DATARAM_BANKSEL_EN
  assign eff_addr = rn_mode ? {3'b000, bank_sel, addr[2:0]} : addr;
`else
  assign eff_addr = addr;
`endif

  logic out_of_range;
  logic bit_bad;
  assign out_of_range = ({1'b0, eff_addr} >= 9'(DEPTH));
  assign bit_bad      = !Bb && ((eff_addr > BIT_LIMIT) || (position == 8'h00));

  state_t        state_q, state_d;
  logic [7:0]    pos_q, pos_d;
  logic          bin_q, bin_d;
  logic [AW-1:0] waddr_q, waddr_d;
  logic          oor_q, oor_d;
  logic          rvalid_q, rvalid_d;
  logic          err_q, err_d;
  logic [7:0]    dout_q, dout_d;
  logic          bout_q, bout_d;

  logic          mem_req, mem_we;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata, mem_rdata;

  always_comb begin
    state_d   = state_q;
    pos_d     = pos_q;
    bin_d     = bin_q;
    waddr_d   = waddr_q;
    oor_d     = oor_q;
    rvalid_d  = 1'b0;
    err_d     = 1'b0;
    dout_d    = dout_q;
    bout_d    = bout_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = eff_addr[AW-1:0];
    mem_wdata = din;
    case (state_q)
      ST_IDLE: begin
        if (req) begin
          pos_d   = position;
          bin_d   = bin;
          waddr_d = eff_addr[AW-1:0];
          oor_d   = out_of_range;
          if (bit_bad) begin
            err_d = 1'b1;
          end else if (out_of_range) begin
            // Out-of-range reads still complete so the requester sees rvalid.
            err_d = 1'b1;
            if (!we) state_d = ST_RDATA;
          end else if (we && Bb) begin
            mem_req = 1'b1;
            mem_we  = 1'b1;
          end else begin
            mem_req = 1'b1;
            state_d = we ? ST_MERGE : ST_RDATA;
          end
        end
      end
      ST_RDATA: begin
        state_d  = ST_IDLE;
        rvalid_d = 1'b1;
        dout_d   = oor_q ? 8'h00 : mem_rdata;
        bout_d   = oor_q ? 1'b0 : |(pos_q & mem_rdata);
      end
      ST_MERGE: begin
        state_d   = ST_IDLE;
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = waddr_q;
        mem_wdata = bit_merge(mem_rdata, pos_q, bin_q);
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      pos_q    <= 8'h00;
      bin_q    <= 1'b0;
      waddr_q  <= '0;
      oor_q    <= 1'b0;
      rvalid_q <= 1'b0;
      err_q    <= 1'b0;
      dout_q   <= 8'h00;
      bout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pos_q    <= pos_d;
      bin_q    <= bin_d;
      waddr_q  <= waddr_d;
      oor_q    <= oor_d;
      rvalid_q <= rvalid_d;
      err_q    <= err_d;
      dout_q   <= dout_d;
      bout_q   <= bout_d;
    end
  end

  // Reset must also block the array port so an interrupted bit write leaves the byte intact.
  data_ram_array #(.DEPTH(DEPTH), .AW(AW)) u_array (
    .clk   (clk),
    .en    (mem_req & ~reset),
    .we    (mem_we),
    .addr  (mem_addr),
    .wdata (mem_wdata),
    .rdata (mem_rdata)
  );

  assign ready  = (state_q == ST_IDLE);
  assign rvalid = rvalid_q;
  assign dout   = dout_q;
  assign bout   = bout_q;
  assign err    = err_q;

endmodule

// File: tb/tb_data_ram_rmw.sv
// Self-checking bench for data_ram_rmw: a 256-byte instance and a 128-byte instance,
// read results checked through a scoreboard queue. Define DATARAM_BANKSEL_EN for bank tests.
module tb_data_ram_rmw;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset = 1'b1;
  logic       req_a = 1'b0, req_b = 1'b0;
  logic       we = 1'b0, bb = 1'b1, bin = 1'b0;
  logic [7:0] addr = 8'h00, position = 8'h00, din = 8'h00;
`ifdef DATARAM_BANKSEL_EN
  logic [1:0] bank_sel = 2'd0;
  logic       rn_mode = 1'b0;
`endif

  logic       ready_a, rvalid_a, bout_a, err_a;
  logic [7:0] dout_a;
  logic       ready_b, rvalid_b, bout_b, err_b;
  logic [7:0] dout_b;

  typedef struct packed {
    logic [7:0] dout;
    logic       bout;
  } rd_exp_t;

  rd_exp_t sb_q[$];
  int checks = 0;
  int passes = 0;

  data_ram_rmw u_dut_a (
    .clk(clk), .reset(reset), .req(req_a), .we(we), .Bb(bb), .addr(addr),
    .position(position), .din(din), .bin(bin),
`ifdef DATARAM_BANKSEL_EN
    .bank_sel(bank_sel), .rn_mode(rn_mode),
`endif
    .ready(ready_a), .rvalid(rvalid_a), .dout(dout_a), .bout(bout_a), .err(err_a)
  );

  data_ram_rmw #(.DEPTH(128)) u_dut_b (
    .clk(clk), .reset(reset), .req(req_b), .we(we), .Bb(bb), .addr(addr),
    .position(position), .din(din), .bin(bin),
`ifdef DATARAM_BANKSEL_EN
    .bank_sel(bank_sel), .rn_mode(rn_mode),
`endif
    .ready(ready_b), .rvalid(rvalid_b), .dout(dout_b), .bout(bout_b), .err(err_b)
  );

  // Drives one request for a single cycle; returns 1 time unit after the accepting edge.
  task automatic issue(input bit sel, input bit w, input bit b, input logic [7:0] a,
                       input logic [7:0] p, input logic [7:0] d, input bit bi);
    @(negedge clk);
    we = w; bb = b; addr = a; position = p; din = d; bin = bi;
    if (sel) req_b = 1'b1; else req_a = 1'b1;
    @(posedge clk);
    #1;
    req_a = 1'b0;
    req_b = 1'b0;
    $display("txn dut=%s %s %s addr=%02h pos=%02h din=%02h bin=%0b",
             sel ? "B" : "A", w ? "wr" : "rd", b ? "byte" : "bit", a, p, d, bi);
  endtask

  // Waits (bounded) for rvalid; lat is cycles counted from the request cycle, -1 on timeout.
  task automatic collect(input bit sel, output int lat, output logic [7:0] d, output logic b);
    lat = -1;
    d = 8'hxx;
    b = 1'bx;
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      if (sel ? rvalid_b : rvalid_a) begin
        lat = i + 1;
        d = sel ? dout_b : dout_a;
        b = sel ? bout_b : bout_a;
        break;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ready_a !== 1'b1) $display("FAIL reset_ready got=%b exp=1", ready_a); else passes++;
    checks++; if (rvalid_a !== 1'b0) $display("FAIL reset_rvalid got=%b exp=0", rvalid_a); else passes++;
    checks++; if (err_a !== 1'b0) $display("FAIL reset_err got=%b exp=0", err_a); else passes++;
    checks++; if (dout_a !== 8'h00) $display("FAIL reset_dout got=%02h exp=00", dout_a); else passes++;
    checks++; if (bout_a !== 1'b0) $display("FAIL reset_bout got=%b exp=0", bout_a); else passes++;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_byte_rw();
    int lat; logic [7:0] d; logic b; rd_exp_t e;
    issue(0, 1, 1, 8'h40, 8'h00, 8'hA5, 0);
    checks++; if (ready_a !== 1'b1 || err_a !== 1'b0)
      $display("FAIL byte_wr_ready_err got=%b%b exp=10", ready_a, err_a); else passes++;
    issue(0, 0, 1, 8'h40, 8'h01, 8'h00, 0);
    sb_q.push_back({8'hA5, 1'b1});
    checks++; if (ready_a !== 1'b0) $display("FAIL byte_rd_busy got=%b exp=0", ready_a); else passes++;
    collect(0, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (lat !== 2) $display("FAIL byte_rd_latency got=%0d exp=2", lat); else passes++;
    checks++; if (d !== e.dout) $display("FAIL byte_rd_dout got=%02h exp=%02h", d, e.dout); else passes++;
    checks++; if (b !== e.bout) $display("FAIL byte_rd_bout got=%b exp=%b", b, e.bout); else passes++;
  endtask

  task automatic test_back_to_back();
    int lat; logic [7:0] d; logic b; rd_exp_t e;
    issue(0, 1, 1, 8'h50, 8'h00, 8'h3C, 0);
    issue(0, 0, 1, 8'h50, 8'h00, 8'h00, 0);
    sb_q.push_back({8'h3C, 1'b0});
    collect(0, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (lat !== 2 || d !== e.dout)
      $display("FAIL b2b_wr_rd got=%02h lat=%0d exp=%02h lat=2", d, lat, e.dout); else passes++;
  endtask

  task automatic test_bit_write();
    int lat; logic [7:0] d; logic b; rd_exp_t e;
    issue(0, 1, 1, 8'h21, 8'h00, 8'h00, 0);
    issue(0, 1, 0, 8'h21, 8'h08, 8'h00, 1);
    checks++; if (ready_a !== 1'b0) $display("FAIL bitwr_busy got=%b exp=0", ready_a); else passes++;
    @(posedge clk);
    #1;
    checks++; if (ready_a !== 1'b1) $display("FAIL bitwr_done got=%b exp=1", ready_a); else passes++;
    issue(0, 0, 1, 8'h21, 8'h00, 8'h00, 0);
    sb_q.push_back({8'h08, 1'b0});
    collect(0, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (d !== e.dout) $display("FAIL bitwr_readback got=%02h exp=%02h", d, e.dout); else passes++;
    // multi-bit clear: FF with mask F0 and bin=0 leaves 0F
    issue(0, 1, 1, 8'h22, 8'h00, 8'hFF, 0);
    issue(0, 1, 0, 8'h22, 8'hF0, 8'h00, 0);
    @(posedge clk);
    #1;
    issue(0, 0, 1, 8'h22, 8'h00, 8'h00, 0);
    sb_q.push_back({8'h0F, 1'b0});
    collect(0, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (d !== e.dout) $display("FAIL bitwr_multi got=%02h exp=%02h", d, e.dout); else passes++;
  endtask

  task automatic test_bit_read();
    int lat; logic [7:0] d; logic b; rd_exp_t e;
    logic [7:0] pos_tab [4] = '{8'h08, 8'h04, 8'h30, 8'h18};
    logic [7:0] adr_tab [4] = '{8'h21, 8'h21, 8'h22, 8'h22};
    logic       exp_tab [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(0, 0, 0, adr_tab[i], pos_tab[i], 8'h00, 0);
      sb_q.push_back({(adr_tab[i] == 8'h21) ? 8'h08 : 8'h0F, exp_tab[i]});
      collect(0, lat, d, b);
      e = sb_q.pop_front();
      checks++; if (b !== e.bout || d !== e.dout || lat !== 2)
        $display("FAIL bitrd_%0d got=%b/%02h lat=%0d exp=%b/%02h lat=2", i, b, d, lat, e.bout, e.dout);
      else passes++;
    end
  endtask

  task automatic test_errors();
    int lat; logic [7:0] d; logic b; rd_exp_t e;
    issue(0, 0, 0, 8'h30, 8'h01, 8'h00, 0);
    checks++; if (err_a !== 1'b1 || ready_a !== 1'b1)
      $display("FAIL bit_above_top got=err%b rdy%b exp=err1 rdy1", err_a, ready_a); else passes++;
    collect(0, lat, d, b);
    checks++; if (lat !== -1) $display("FAIL bit_above_top_rvalid got=%0d exp=-1", lat); else passes++;
    issue(0, 1, 0, 8'h21, 8'h00, 8'h00, 1);
    checks++; if (err_a !== 1'b1 || ready_a !== 1'b1)
      $display("FAIL bit_pos_zero got=err%b rdy%b exp=err1 rdy1", err_a, ready_a); else passes++;
    // depth-128 instance
    issue(1, 1, 1, 8'h10, 8'h00, 8'h99, 0);
    issue(1, 1, 1, 8'h30, 8'h00, 8'h66, 0);
    issue(1, 1, 1, 8'h90, 8'h00, 8'h11, 0);
    checks++; if (err_b !== 1'b1) $display("FAIL oor_write_err got=%b exp=1", err_b); else passes++;
    issue(1, 0, 1, 8'h10, 8'hFF, 8'h00, 0);
    sb_q.push_back({8'h99, 1'b1});
    collect(1, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (d !== e.dout) $display("FAIL oor_write_dropped got=%02h exp=%02h", d, e.dout); else passes++;
    issue(1, 0, 1, 8'h90, 8'hFF, 8'h00, 0);
    sb_q.push_back({8'h00, 1'b0});
    checks++; if (err_b !== 1'b1) $display("FAIL oor_read_err got=%b exp=1", err_b); else passes++;
    collect(1, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (lat !== 2 || d !== e.dout || b !== e.bout)
      $display("FAIL oor_read got=%02h/%b lat=%0d exp=%02h/%b lat=2", d, b, lat, e.dout, e.bout);
    else passes++;
    issue(1, 1, 0, 8'h30, 8'h01, 8'h00, 1);
    checks++; if (err_b !== 1'b1) $display("FAIL b_bitwr_30_err got=%b exp=1", err_b); else passes++;
    issue(1, 0, 1, 8'h30, 8'h00, 8'h00, 0);
    sb_q.push_back({8'h66, 1'b0});
    collect(1, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (d !== e.dout) $display("FAIL b_bitwr_30_unchanged got=%02h exp=%02h", d, e.dout); else passes++;
  endtask

  task automatic test_reset_abort();
    int lat; logic [7:0] d; logic b; rd_exp_t e;
    issue(0, 1, 1, 8'h22, 8'h00, 8'h5A, 0);
    issue(0, 1, 0, 8'h22, 8'h81, 8'h00, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checks++; if (ready_a !== 1'b1) $display("FAIL merge_reset_ready got=%b exp=1", ready_a); else passes++;
    issue(0, 0, 1, 8'h22, 8'h00, 8'h00, 0);
    sb_q.push_back({8'h5A, 1'b0});
    collect(0, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (d !== e.dout) $display("FAIL merge_reset_abort got=%02h exp=%02h", d, e.dout); else passes++;
    issue(0, 0, 1, 8'h22, 8'h00, 8'h00, 0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    collect(0, lat, d, b);
    checks++; if (lat !== -1) $display("FAIL rdata_reset_rvalid got=lat%0d exp=none", lat); else passes++;
  endtask

`ifdef DATARAM_BANKSEL_EN
  task automatic test_banksel();
    int lat; logic [7:0] d; logic b; rd_exp_t e;
    bank_sel = 2'd2;
    rn_mode = 1'b1;
    issue(0, 1, 1, 8'hE3, 8'h00, 8'h77, 0);
    rn_mode = 1'b0;
    bank_sel = 2'd0;
    issue(0, 0, 1, 8'h13, 8'h00, 8'h00, 0);
    sb_q.push_back({8'h77, 1'b0});
    collect(0, lat, d, b);
    e = sb_q.pop_front();
    checks++; if (d !== e.dout) $display("FAIL banksel_r3 got=%02h exp=%02h", d, e.dout); else passes++;
  endtask
`endif

  initial begin
    test_reset();
    test_byte_rw();
    test_back_to_back();
    test_bit_write();
    test_bit_read();
    test_errors();
    test_reset_abort();
`ifdef DATARAM_BANKSEL_EN
    test_banksel();
`endif
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
